// File: rtl/controlador_banco_if.sv
// Request/response and register-bank bus of the bank controller.
// The controller takes the slave side; the requester and the bank together form the master side.
interface controlador_banco_if;
  logic        req_valido;
  logic        req_pronto;
  logic [1:0]  req_op;
  logic [2:0]  req_reg_a;
  logic [2:0]  req_reg_b;
  logic [31:0] req_dado;
  logic        resp_valido;
  logic [31:0] resp_dado;
  logic        resp_aceito;
  logic [2:0]  n_reg;
  logic        escrita;
  logic [31:0] dado_escrito;
  logic [31:0] dado_lido;

  modport slave (
    input  req_valido, req_op, req_reg_a, req_reg_b, req_dado, resp_aceito, dado_lido,
    output req_pronto, resp_valido, resp_dado, n_reg, escrita, dado_escrito
  );

  modport master (
    output req_valido, req_op, req_reg_a, req_reg_b, req_dado, resp_aceito, dado_lido,
    input  req_pronto, resp_valido, resp_dado, n_reg, escrita, dado_escrito
  );
endinterface

// File: rtl/controlador_banco.sv
// Register-bank controller: serialises LER/ESCREVER/COPIAR/SOMAR requests into
// bank read/write cycles; every output comes from a register updated by the FSM.
module controlador_banco (
  input  logic                        clk,
  input  logic                        reset,
  controlador_banco_if.slave          bus
);

  localparam logic [1:0] OP_LER      = 2'b00;
  localparam logic [1:0] OP_ESCREVER = 2'b01;
  localparam logic [1:0] OP_COPIAR   = 2'b10;
  localparam logic [1:0] OP_SOMAR    = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO,
    LER_EMITE,
    LER_CAPTURA,
    ESCREVE,
    RESPOSTA
  } estado_t;

  estado_t     r_estado;
  logic [1:0]  r_op;
  logic [2:0]  r_reg_a;
  logic [2:0]  r_reg_b;
  logic [31:0] r_dado;
  logic [31:0] r_captura;
  logic        r_pronto;
  logic        r_escrita;
  logic [2:0]  r_n_reg;
  logic [31:0] r_dado_escrito;
  logic        r_resp_valido;
  logic [31:0] r_resp_dado;
  logic [31:0] w_captura;

  // The bank answers one edge after the read is issued, so dado_lido is valid in LER_CAPTURA.
  assign w_captura = (r_op == OP_SOMAR) ? (bus.dado_lido + r_dado) : bus.dado_lido;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_op           <= 2'b00;
      r_reg_a        <= 3'd0;
      r_reg_b        <= 3'd0;
      r_dado         <= 32'd0;
      r_captura      <= 32'd0;
      r_pronto       <= 1'b1;
      r_escrita      <= 1'b0;
      r_n_reg        <= 3'd0;
      r_dado_escrito <= 32'd0;
      r_resp_valido  <= 1'b0;
      r_resp_dado    <= 32'd0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (bus.req_valido && r_pronto) begin
            r_op     <= bus.req_op;
            r_reg_a  <= bus.req_reg_a;
            r_reg_b  <= bus.req_reg_b;
            r_dado   <= bus.req_dado;
            r_pronto <= 1'b0;
            r_n_reg  <= bus.req_reg_a;
            if (bus.req_op == OP_ESCREVER) begin
              r_estado       <= ESCREVE;
              r_escrita      <= 1'b1;
              r_dado_escrito <= bus.req_dado;
            end else begin
              r_estado <= LER_EMITE;
            end
          end
        end
        LER_EMITE: begin
          r_estado <= LER_CAPTURA;
        end
        LER_CAPTURA: begin
          r_captura <= w_captura;
          if (r_op == OP_LER) begin
            r_estado      <= RESPOSTA;
            r_n_reg       <= 3'd0;
            r_resp_valido <= 1'b1;
            r_resp_dado   <= w_captura;
          end else begin
            r_estado       <= ESCREVE;
            r_escrita      <= 1'b1;
            r_n_reg        <= (r_op == OP_COPIAR) ? r_reg_b : r_reg_a;
            r_dado_escrito <= w_captura;
          end
        end
        ESCREVE: begin
          r_estado       <= RESPOSTA;
          r_escrita      <= 1'b0;
          r_n_reg        <= 3'd0;
          r_dado_escrito <= 32'd0;
          r_resp_valido  <= 1'b1;
          r_resp_dado    <= (r_op == OP_ESCREVER) ? r_dado : r_captura;
        end
        RESPOSTA: begin
          if (bus.resp_aceito) begin
            r_estado      <= OCIOSO;
            r_pronto      <= 1'b1;
            r_resp_valido <= 1'b0;
            r_resp_dado   <= 32'd0;
          end
        end
        default: begin
          r_estado       <= OCIOSO;
          r_pronto       <= 1'b1;
          r_escrita      <= 1'b0;
          r_n_reg        <= 3'd0;
          r_dado_escrito <= 32'd0;
          r_resp_valido  <= 1'b0;
          r_resp_dado    <= 32'd0;
        end
      endcase
    end
  end

  // Reset gates the strobe directly so a reset landing mid-ESCREVE never commits the write.
  assign bus.escrita      = r_escrita & ~reset;
  assign bus.req_pronto   = r_pronto & ~reset;
  assign bus.n_reg        = r_n_reg;
  assign bus.dado_escrito = r_dado_escrito;
  assign bus.resp_valido  = r_resp_valido;
  assign bus.resp_dado    = r_resp_dado;

endmodule

// File: doc/controlador_banco.md
CONTROLADOR_BANCO -- requirements
Module: controlador_banco

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valido  in  1  request present.
- req_pronto  out  1  controller can accept a request.
- req_op  in  2  operation: 00 LER, 01 ESCREVER, 10 COPIAR, 11 SOMAR.
- req_reg_a  in  3  source/target register.
- req_reg_b  in  3  destination register (COPIAR only).
- req_dado  in  32  write data (ESCREVER) or addend (SOMAR).
- resp_valido  out  1  response present.
- resp_dado  out  32  response value.
- resp_aceito  in  1  requester takes the response.
- n_reg  out  3  bank register number.
- escrita  out  1  bank write strobe; 0 means the bank performs a read.
- dado_escrito  out  32  bank write data.
- dado_lido  in  32  bank read data, registered by the bank one edge after the read is issued.
REQ-002 SHALL use one clock and a synchronous, active-high reset; there are no parameters.

Function
REQ-003 SHALL implement FSM states OCIOSO, LER_EMITE, LER_CAPTURA, ESCREVE, RESPOSTA.
REQ-004 SHALL assert req_pronto only in OCIOSO; a request is accepted at the posedge where req_valido=1 and req_pronto=1.
REQ-005 SHALL latch req_op, req_reg_a, req_reg_b and req_dado at acceptance; later input changes have no effect until RESPOSTA exits.
REQ-006 SHALL follow these transitions after acceptance:
- LER, COPIAR, SOMAR go to LER_EMITE.
- ESCREVER goes to ESCREVE.
- LER_EMITE goes to LER_CAPTURA.
- LER_CAPTURA goes to RESPOSTA for LER, else to ESCREVE.
- ESCREVE goes to RESPOSTA.
- RESPOSTA goes to OCIOSO on the edge where resp_aceito=1, else it holds.
REQ-007 SHALL, in LER_EMITE, drive escrita=0 and n_reg=latched reg_a.
REQ-008 SHALL, in LER_CAPTURA, drive escrita=0 and n_reg=latched reg_a, and store into an internal 32-bit register on that edge:
- dado_lido for LER and COPIAR;
- dado_lido + latched req_dado, modulo 2^32 with carry discarded, for SOMAR.
REQ-009 SHALL, in ESCREVE, drive escrita=1 and select the bank target and data as follows:
- ESCREVER: n_reg=reg_a, dado_escrito=req_dado.
- COPIAR: n_reg=reg_b, dado_escrito=captured value.
- SOMAR: n_reg=reg_a, dado_escrito=captured sum.
REQ-010 SHALL assert escrita for exactly one cycle per ESCREVER, COPIAR or SOMAR, and never for LER.
REQ-011 SHALL drive escrita=0, n_reg=0 and dado_escrito=0 in OCIOSO and RESPOSTA.
REQ-012 SHALL drive resp_valido=1 only in RESPOSTA, with resp_dado held stable until acceptance:
- LER returns the value read.
- ESCREVER returns req_dado.
- COPIAR returns the copied value.
- SOMAR returns the new sum.
REQ-013 SHALL drive resp_dado=0 outside RESPOSTA.
REQ-014 SHALL meet these latencies, counted from the acceptance edge to the first cycle with resp_valido=1:
- ESCREVER: 2 cycles.
- LER: 3 cycles.
- COPIAR and SOMAR: 4 cycles.
REQ-015 SHALL derive all bank-side outputs from registered state only, with no combinational path from req_* inputs; the only exception is the reset gating in REQ-018.
REQ-016 SHALL handle COPIAR with reg_a=reg_b as a normal read then write of the same value; the bank content is unchanged.
REQ-017 SHALL allow back-to-back operation: with resp_aceito held at 1, RESPOSTA lasts one cycle and a new request is accepted in the following OCIOSO cycle.

Reset
REQ-018 SHALL, while reset=1, force escrita=0 combinationally, so no bank write occurs on a reset edge even mid-ESCREVE.
REQ-019 SHALL, on a reset edge, enter OCIOSO and clear the latched request and the captured register to 0; bank contents are not affected.
REQ-020 SHALL hold req_pronto=0 while reset=1, and set req_pronto=1 from the first cycle after reset deasserts.
REQ-021 SHALL hold these values after reset: resp_valido=0, resp_dado=0, n_reg=0, dado_escrito=0.

Verification
REQ-022 ESCREVER reg 3 = 1001, then LER reg 3: escrita pulses once with n_reg=3; the write response is 1001 at +2 cycles; the read response is 1001 at +3 cycles.
REQ-023 ESCREVER reg 7 = 511, then COPIAR a=7, b=1, then LER reg 1: the copy response is 511 at +4 cycles and the read returns 511.
REQ-024 ESCREVER reg 0 = 0xFFFFFFFF, then SOMAR a=0 with dado 2: the response is 1 (wrap-around) and a subsequent LER reg 0 returns 1.
REQ-025 LER with resp_aceito held 0 for 5 cycles: resp_valido and resp_dado stay stable; req_pronto stays 0; a second req_valido is ignored until acceptance.
REQ-026 Assert reset during the ESCREVE cycle of ESCREVER reg 2 = 77, with reg 2 previously holding 5: escrita observed 0; LER reg 2 after reset returns 5; req_pronto=1 the cycle after reset deasserts.
REQ-027 Send 4 requests back-to-back with resp_aceito=1: each is accepted the cycle after the previous RESPOSTA; no cycle has escrita=1 outside ESCREVE.
